axis_pkt_sink: RTL
==================

Name: axis_pkt_sink

Overview:
- Terminal AXI-Stream consumer placed directly downstream of the LFSR number generator, or at a NoC router egress port.
- Accepts packets and checks the destination of the first beat and the packet length.
- Accumulates a per-packet modulo sum of the data beats.
- Exposes packet and error counters plus a one-cycle completion report for the bench and scoreboard.

Parameters:
- TDATAW, 32, stream data width.
- TDESTW, 4, TDEST width.
- TIDW, 2, TID width (sampled, not checked).
- MY_DEST, 4'h1, expected TDEST of every packet.
- MAX_BEATS, 16, maximum legal beats per packet (must be >= 1).
- CNTW, 16, width of the packet and error counters.
- SUMW, 40, width of the per-packet data sum.

Ports:
- CLK, in, 1: clock.
- RST_N, in, 1: synchronous active-low reset.
- ENABLE, in, 1: gates TREADY; 0 stalls the stream.
- CLEAR, in, 1: synchronous zeroing of counters and sticky errors.
- AXIS_S_TVALID, in, 1: slave valid.
- AXIS_S_TREADY, out, 1: slave ready.
- AXIS_S_TDATA, in, TDATAW: slave data.
- AXIS_S_TLAST, in, 1: last beat of packet.
- AXIS_S_TID, in, TIDW: stream ID.
- AXIS_S_TDEST, in, TDESTW: destination.
- PKT_DONE, out, 1: one-cycle pulse; a good packet completed.
- PKT_SUM, out, SUMW: sum of the last good packet (held).
- PKT_LEN, out, 8: beat count of the last good packet (held).
- PKT_TID, out, TIDW: TID of the first beat of the last good packet (held).
- PKT_COUNT, out, CNTW: count of good packets.
- DROP_COUNT, out, CNTW: count of dropped packets.
- ERR_DEST, out, 1: sticky; a TDEST mismatch was seen.
- ERR_LEN, out, 1: sticky; an over-length packet was seen.

Behaviour:
- Reset: all outputs, counters, state and the accumulator go to 0 on the CLK edge where RST_N==0. Reset mid-packet abandons the packet silently; DROP_COUNT is not incremented.
- Handshake: a beat is accepted when TVALID & TREADY. TREADY is registered: it is 1 in the cycle after ENABLE==1 is sampled while the next state is not REPORT, and it is 0 in REPORT. Deasserting ENABLE takes effect one cycle later.
- The sink never asserts TREADY combinationally from TVALID.
- FSM states: IDLE, RECV, DROP, REPORT.
- IDLE, on an accepted beat:
  - TDEST != MY_DEST: set ERR_DEST. If TLAST, increment DROP_COUNT and stay in IDLE; else go to DROP.
  - TDEST ok and TLAST (single-beat packet): sum = zero-extended TDATA, len = 1, go to REPORT.
  - TDEST ok, no TLAST: the accumulator loads TDATA, beat count = 1, TID is captured, go to RECV.
- RECV, on an accepted beat:
  - The accumulator adds TDATA, wrapping modulo 2^SUMW. The beat count increments.
  - TDEST is not rechecked.
  - TLAST on a beat count <= MAX_BEATS goes to REPORT.
  - If the beat count reaches MAX_BEATS without TLAST, set ERR_LEN and go to DROP.
- DROP: accepts and discards beats. On TLAST, increment DROP_COUNT and return to IDLE.
- REPORT (exactly one cycle):
  - PKT_DONE = 1.
  - PKT_SUM, PKT_LEN and PKT_TID update.
  - PKT_COUNT increments.
  - TREADY = 0; go to IDLE.
- Report latency: PKT_DONE is high in the cycle after the TLAST beat is accepted.
- Counter saturation: PKT_COUNT and DROP_COUNT saturate at all-ones and do not wrap.
- CLEAR:
  - Zeroes PKT_COUNT, DROP_COUNT, ERR_DEST and ERR_LEN. It does not affect the FSM or a packet in flight.
  - If CLEAR coincides with an increment, CLEAR wins.
  - If CLEAR coincides with an error event, the error flag ends up set.
- ENABLE=0 mid-packet: the FSM holds its state and accumulator until beats resume.
- TID, TDATA and TDEST are ignored when TVALID is low.

Decomposition:
- Shared package axis_sink_pkg holds:
  - state_t enum {IDLE, RECV, DROP, REPORT};
  - the SUMW and CNTW default localparams;
  - a sat_inc function for the saturating counters.
- One sub-module, sat_counter (parameter CNTW; ports inc and clr), instanced twice for PKT_COUNT and DROP_COUNT.
- The FSM and accumulator stay in the top module.

Test Plan:
- Reset, then ENABLE=1 and a 3-beat packet (TDEST=1, TID=2, data 0x05, 0x10, 0xFF with TLAST) -> one cycle after the last beat: PKT_DONE=1, PKT_SUM=0x114, PKT_LEN=3, PKT_TID=2, PKT_COUNT=1.
- Single-beat packet (TDEST=1, data 0xAB, TLAST) -> PKT_SUM=0xAB, PKT_LEN=1. TREADY=0 in the REPORT cycle, and a back-to-back beat offered then is held until the next cycle.
- 2-beat packet with TDEST=3 -> ERR_DEST=1, DROP_COUNT=1, no PKT_DONE, PKT_COUNT unchanged.
- 20-beat packet with MAX_BEATS=16 -> ERR_LEN set after the 16th beat, remaining beats drained, DROP_COUNT+1, and a following good packet is reported normally.
- ENABLE toggled every 2 cycles during a 4-beat packet (data 0xFFFFFFFF x4) -> PKT_SUM=0x3FFFFFFFC, no beat lost or duplicated. RST_N=0 mid-packet -> all outputs 0 and no report.
- CLEAR asserted in the same cycle as REPORT -> PKT_COUNT=0 afterwards, ERR flags cleared, PKT_SUM still updated.

Source files
------------

// File: rtl/axis_pkt_sink_pkg.sv
// rtl/axis_pkt_sink_pkg.sv - shared types, defaults and helpers for the packet sink
//
// Purpose : FSM state encoding, default widths and the saturating-increment
//           helper used by the sink counters.
// Ports   : none (package).
package axis_sink_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DROP   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int SUMW_DEF = 40;
  localparam int CNTW_DEF = 16;

  // Counters narrower than this are widened before calling sat_inc.
  localparam int SATW = 64;

  function automatic logic [SATW-1:0] sat_inc(input logic [SATW-1:0] val,
                                              input logic [SATW-1:0] max_val);
    return (val == max_val) ? val : val + SATW'(1);
  endfunction

endpackage

// File: rtl/axis_pkt_sink_if.sv
// rtl/axis_pkt_sink_if.sv - AXI-Stream style bundle feeding the packet sink
//
// Purpose : groups the stream handshake, payload and sideband signals.
// Ports   : tvalid/tdata/tlast/tid/tdest from master, tready from slave.
interface axis_pkt_sink_if #(
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2
);
  logic              tvalid;
  logic              tready;
  logic [TDATAW-1:0] tdata;
  logic              tlast;
  logic [TIDW-1:0]   tid;
  logic [TDESTW-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_pkt_sink_sat_counter.sv
// rtl/axis_pkt_sink_sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose : counts single-cycle events, sticks at all-ones, clear beats increment.
// Ports   : clk, rst_n (sync active-low), inc, clr, count.
module sat_counter
  import axis_sink_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clr,
  output logic [CNTW-1:0] count
);

  localparam logic [SATW-1:0] MAXV = SATW'({CNTW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= CNTW'(sat_inc(SATW'(count), MAXV));
    end
  end

endmodule

// File: rtl/axis_pkt_sink.sv
// rtl/axis_pkt_sink.sv - terminal stream consumer with dest/length checks and sums
//
// Purpose : accepts packets, checks first-beat TDEST and length, sums the beats
//           modulo 2^SUMW and reports each good packet with a one-cycle pulse.
// Ports   : CLK, RST_N (sync active-low), ENABLE (gates TREADY), CLEAR,
//           AXIS_S (stream slave), PKT_DONE/PKT_SUM/PKT_LEN/PKT_TID (report),
//           PKT_COUNT/DROP_COUNT (saturating), ERR_DEST/ERR_LEN (sticky).
module axis_pkt_sink
  import axis_sink_pkg::*;
#(
  parameter int                TDATAW    = 32,
  parameter int                TDESTW    = 4,
  parameter int                TIDW      = 2,
  parameter logic [TDESTW-1:0] MY_DEST   = 4'h1,
  parameter int                MAX_BEATS = 16,
  parameter int                CNTW      = CNTW_DEF,
  parameter int                SUMW      = SUMW_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              CLEAR,
  axis_pkt_sink_if.slave    AXIS_S,
  output logic              PKT_DONE,
  output logic [SUMW-1:0]   PKT_SUM,
  output logic [7:0]        PKT_LEN,
  output logic [TIDW-1:0]   PKT_TID,
  output logic [CNTW-1:0]   PKT_COUNT,
  output logic [CNTW-1:0]   DROP_COUNT,
  output logic              ERR_DEST,
  output logic              ERR_LEN
);

  localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

  state_t            state, state_nxt;
  logic              tready_q;
  logic [SUMW-1:0]   acc;
  logic [7:0]        cnt;
  logic [TIDW-1:0]   tid_q;

  logic              accept;
  logic              dest_ok;
  logic [SUMW-1:0]   beat;
  logic [SUMW-1:0]   acc_sum;
  logic [7:0]        cnt_inc;

  logic              good_last, drop_inc, first_load, beat_add, set_ed, set_el;
  logic [SUMW-1:0]   rpt_sum;
  logic [7:0]        rpt_len;
  logic [TIDW-1:0]   rpt_tid;

  assign AXIS_S.tready = tready_q;
  assign accept        = AXIS_S.tvalid & tready_q;
  assign dest_ok       = (AXIS_S.tdest == MY_DEST);
  assign beat          = SUMW'(AXIS_S.tdata);
  assign acc_sum       = acc + beat;
  assign cnt_inc       = cnt + 8'd1;
  assign PKT_DONE      = (state == REPORT);

  always_comb begin
    state_nxt  = state;
    good_last  = 1'b0;
    drop_inc   = 1'b0;
    first_load = 1'b0;
    beat_add   = 1'b0;
    set_ed     = 1'b0;
    set_el     = 1'b0;
    rpt_sum    = acc_sum;
    rpt_len    = cnt_inc;
    rpt_tid    = tid_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!dest_ok) begin
            set_ed = 1'b1;
            if (AXIS_S.tlast) drop_inc  = 1'b1;
            else              state_nxt = DROP;
          end else if (AXIS_S.tlast) begin
            good_last = 1'b1;
            rpt_sum   = beat;
            rpt_len   = 8'd1;
            rpt_tid   = AXIS_S.tid;
            state_nxt = REPORT;
          end else begin
            first_load = 1'b1;
            // A one-beat limit means the first non-last beat is already over-length.
            if (MAX_B <= 8'd1) begin
              set_el    = 1'b1;
              state_nxt = DROP;
            end else begin
              state_nxt = RECV;
            end
          end
        end
      end
      RECV: begin
        if (accept) begin
          beat_add = 1'b1;
          if (AXIS_S.tlast) begin
            good_last = 1'b1;
            state_nxt = REPORT;
          end else if (cnt_inc >= MAX_B) begin
            set_el    = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (accept && AXIS_S.tlast) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      tready_q <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      tid_q    <= '0;
      PKT_SUM  <= '0;
      PKT_LEN  <= '0;
      PKT_TID  <= '0;
      ERR_DEST <= 1'b0;
      ERR_LEN  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Ready looks one state ahead so the REPORT cycle never takes a beat.
      tready_q <= ENABLE && (state_nxt != REPORT);
      if (first_load) begin
        acc   <= beat;
        cnt   <= 8'd1;
        tid_q <= AXIS_S.tid;
      end else if (beat_add) begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
      // Report fields land on the edge into REPORT so they are valid with PKT_DONE.
      if (good_last) begin
        PKT_SUM <= rpt_sum;
        PKT_LEN <= rpt_len;
        PKT_TID <= rpt_tid;
      end
      // A new error outranks a simultaneous clear.
      if (set_ed)     ERR_DEST <= 1'b1;
      else if (CLEAR) ERR_DEST <= 1'b0;
      if (set_el)     ERR_LEN  <= 1'b1;
      else if (CLEAR) ERR_LEN  <= 1'b0;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_pkt_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (good_last),
    .clr   (CLEAR),
    .count (PKT_COUNT)
  );

  sat_counter #(.CNTW(CNTW)) u_drop_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (drop_inc),
    .clr   (CLEAR),
    .count (DROP_COUNT)
  );

endmodule
